// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin arbiter sharing one BRAM port between two clients.
// Grants are combinational; responses arrive exactly one cycle after the grant.
module bram_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_BYTES  = DATA_WIDTH / 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  reqValid_0,
    input  logic                  reqValid_1,
    output logic                  reqReady_0,
    output logic                  reqReady_1,
    input  logic                  reqWrite_0,
    input  logic                  reqWrite_1,
    input  logic [NUM_BYTES-1:0]  reqByteEnable_0,
    input  logic [NUM_BYTES-1:0]  reqByteEnable_1,
    input  logic [ADDR_WIDTH-1:0] reqAddress_0,
    input  logic [ADDR_WIDTH-1:0] reqAddress_1,
    input  logic [DATA_WIDTH-1:0] reqWriteData_0,
    input  logic [DATA_WIDTH-1:0] reqWriteData_1,
    output logic                  respValid_0,
    output logic                  respValid_1,
    output logic [DATA_WIDTH-1:0] respData_0,
    output logic [DATA_WIDTH-1:0] respData_1,
    output logic                  readEnable,
    output logic                  writeEnable,
    output logic [NUM_BYTES-1:0]  writeByteEnable,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] writeData,
    input  logic [DATA_WIDTH-1:0] readData
);
    logic prio, grantValid, grantClient, grantWrite;
    logic anyGrant, selWrite;
    always_comb begin
        reqReady_0 = !reset && reqValid_0 && (!reqValid_1 || !prio);
        reqReady_1 = !reset && reqValid_1 && (!reqValid_0 || prio);
        anyGrant = reqReady_0 || reqReady_1;
        selWrite = reqReady_1 ? reqWrite_1 : reqWrite_0;
        readEnable = anyGrant && !selWrite;
        writeEnable = anyGrant && selWrite;
        address = !anyGrant ? '0 : reqReady_1 ? reqAddress_1 : reqAddress_0;
        writeByteEnable = !writeEnable ? '0 : reqReady_1 ? reqByteEnable_1 : reqByteEnable_0;
        writeData = !writeEnable ? '0 : reqReady_1 ? reqWriteData_1 : reqWriteData_0;
        // Reset masks a response still in flight from the cycle before reset.
        respValid_0 = !reset && grantValid && !grantClient;
        respValid_1 = !reset && grantValid && grantClient;
        respData_0 = (respValid_0 && !grantWrite) ? readData : '0;
        respData_1 = (respValid_1 && !grantWrite) ? readData : '0;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            prio        <= 1'b0;
            grantValid  <= 1'b0;
            grantClient <= 1'b0;
            grantWrite  <= 1'b0;
        end else begin
            grantValid <= anyGrant;
            if (anyGrant) begin
                prio        <= reqReady_0;
                grantClient <= reqReady_1;
                grantWrite  <= selWrite;
            end
        end
    end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed and random checks of bram_port_arbiter against a
// transaction-level reference model, with a behavioural BRAM stub on the shared port.
module tb_bram_port_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic        reqValid_0, reqValid_1, reqReady_0, reqReady_1;
    logic        reqWrite_0, reqWrite_1;
    logic [3:0]  reqByteEnable_0, reqByteEnable_1;
    logic [7:0]  reqAddress_0, reqAddress_1;
    logic [31:0] reqWriteData_0, reqWriteData_1;
    logic        respValid_0, respValid_1;
    logic [31:0] respData_0, respData_1;
    logic        readEnable, writeEnable;
    logic [3:0]  writeByteEnable;
    logic [7:0]  address;
    logic [31:0] writeData;
    logic [31:0] readData = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] bram [256] = '{default: '0};
    logic [31:0] refMem [256] = '{default: '0};
    int          mPrio = 0;
    bit          pendValid = 0, pendWrite = 0;
    int          pendClient = 0;
    logic [31:0] pendData = '0;

    always #5 clock = ~clock;

    bram_port_arbiter dut (
        .clock(clock), .reset(reset),
        .reqValid_0(reqValid_0), .reqValid_1(reqValid_1),
        .reqReady_0(reqReady_0), .reqReady_1(reqReady_1),
        .reqWrite_0(reqWrite_0), .reqWrite_1(reqWrite_1),
        .reqByteEnable_0(reqByteEnable_0), .reqByteEnable_1(reqByteEnable_1),
        .reqAddress_0(reqAddress_0), .reqAddress_1(reqAddress_1),
        .reqWriteData_0(reqWriteData_0), .reqWriteData_1(reqWriteData_1),
        .respValid_0(respValid_0), .respValid_1(respValid_1),
        .respData_0(respData_0), .respData_1(respData_1),
        .readEnable(readEnable), .writeEnable(writeEnable),
        .writeByteEnable(writeByteEnable), .address(address),
        .writeData(writeData), .readData(readData)
    );

    always @(posedge clock) begin
        if (writeEnable)
            for (int b = 0; b < 4; b++)
                if (writeByteEnable[b]) bram[address][8*b +: 8] <= writeData[8*b +: 8];
        if (readEnable) readData <= bram[address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setReq(input int c, input bit v, input bit w, input logic [3:0] be,
                          input logic [7:0] a, input logic [31:0] d);
        if (c == 0) begin
            reqValid_0 = v; reqWrite_0 = w; reqByteEnable_0 = be; reqAddress_0 = a; reqWriteData_0 = d;
        end else begin
            reqValid_1 = v; reqWrite_1 = w; reqByteEnable_1 = be; reqAddress_1 = a; reqWriteData_1 = d;
        end
    endtask

    task automatic idle();
        setReq(0, 0, 0, 4'h0, 8'h0, 32'h0);
        setReq(1, 0, 0, 4'h0, 8'h0, 32'h0);
    endtask

    task automatic cycle();
        int g;
        bit gw, rv0, rv1;
        logic [7:0] ga;
        logic [3:0] gbe;
        logic [31:0] gd;
        @(negedge clock);
        g = reset ? -1 : (reqValid_0 && reqValid_1) ? mPrio : reqValid_0 ? 0 : reqValid_1 ? 1 : -1;
        gw  = (g == 1) ? reqWrite_1 : reqWrite_0;
        ga  = (g == 1) ? reqAddress_1 : reqAddress_0;
        gbe = (g == 1) ? reqByteEnable_1 : reqByteEnable_0;
        gd  = (g == 1) ? reqWriteData_1 : reqWriteData_0;
        chk("reqReady_0", reqReady_0, g == 0);
        chk("reqReady_1", reqReady_1, g == 1);
        chk("readEnable", readEnable, g >= 0 && !gw);
        chk("writeEnable", writeEnable, g >= 0 && gw);
        if (g < 0) begin
            chk("idle address", address, 0);
            chk("idle writeByteEnable", writeByteEnable, 0);
            chk("idle writeData", writeData, 0);
        end else begin
            chk("address", address, ga);
            if (gw) begin
                chk("writeByteEnable", writeByteEnable, gbe);
                chk("writeData", writeData, gd);
            end
        end
        rv0 = !reset && pendValid && pendClient == 0;
        rv1 = !reset && pendValid && pendClient == 1;
        chk("respValid_0", respValid_0, rv0);
        chk("respValid_1", respValid_1, rv1);
        if (!rv0) chk("respData_0 idle", respData_0, 0);
        else if (!pendWrite) chk("respData_0", respData_0, pendData);
        if (!rv1) chk("respData_1 idle", respData_1, 0);
        else if (!pendWrite) chk("respData_1", respData_1, pendData);
        @(posedge clock);
        #1;
        if (reset) begin
            mPrio = 0;
            pendValid = 0;
        end else begin
            pendValid = g >= 0;
            if (g >= 0) begin
                mPrio = 1 - g;
                pendClient = g;
                pendWrite = gw;
                pendData = refMem[ga];
                if (gw)
                    for (int b = 0; b < 4; b++)
                        if (gbe[b]) refMem[ga][8*b +: 8] = gd[8*b +: 8];
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        cycle();
        cycle();
        reset = 1'b0;
        // idle bus after reset
        cycle();
        cycle();
        // client 0 write then read back
        setReq(0, 1, 1, 4'hF, 8'd0, 32'h0000_000A);
        cycle();
        setReq(0, 1, 0, 4'h0, 8'd0, 32'h0);
        cycle();
        idle();
        cycle();
        // both clients read continuously: alternating grants
        setReq(0, 1, 0, 4'h0, 8'd0, 32'h0);
        setReq(1, 1, 0, 4'h0, 8'd0, 32'h0);
        repeat (4) cycle();
        idle();
        cycle();
        // client 1 partial byte-lane write over zero
        setReq(1, 1, 1, 4'hF, 8'd1, 32'h0);
        cycle();
        setReq(1, 1, 1, 4'h3, 8'd1, 32'hDDDD_EEEE);
        cycle();
        setReq(1, 1, 0, 4'h0, 8'd1, 32'h0);
        cycle();
        idle();
        cycle();
        // only client 1 valid with prio on client 0
        setReq(1, 1, 0, 4'h0, 8'd1, 32'h0);
        repeat (3) cycle();
        idle();
        cycle();
        // reset right after a client 0 read grant
        setReq(0, 1, 0, 4'h0, 8'd0, 32'h0);
        cycle();
        idle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        setReq(0, 1, 0, 4'h0, 8'd2, 32'h0);
        setReq(1, 1, 0, 4'h0, 8'd3, 32'h0);
        cycle();
        idle();
        cycle();
        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            for (int c = 0; c < 2; c++)
                setReq(c, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                       4'($urandom), 8'($urandom_range(0, 7)), $urandom);
            cycle();
        end
        reset = 1'b0;
        idle();
        cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
